// File: rtl/tc_pulse_train.sv
// Burst pulse generator: after start_i, emits BURST single-cycle ticks spaced PERIOD
// cycles apart, then a one-cycle done pulse. Terminal counts come from counter MSBs only.
module tc_pulse_train #(
  parameter int unsigned PERIOD = 100,
  parameter int unsigned BURST  = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic abort_i,
  output logic busy_o,
  output logic tick_o,
  output logic done_o
);

  localparam int unsigned PCLOG = $clog2(PERIOD);
  localparam int unsigned BCLOG = $clog2(BURST);
  localparam int unsigned PW    = PCLOG + 1;
  localparam int unsigned BW    = BCLOG + 1;

  // Counters start at (2^clog2(N) - N) so the MSB sets after exactly N increments.
  localparam logic [PW-1:0] PSTART  = PW'(1) << PCLOG;
  localparam logic [PW-1:0] PSTOP   = PSTART - PW'(PERIOD);
  localparam logic [PW-1:0] PRELOAD = PSTOP + PW'(1);
  localparam logic [BW-1:0] BSTART  = BW'(1) << BCLOG;
  localparam logic [BW-1:0] BSTOP   = BSTART - BW'(BURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [PW-1:0]   pcnt_reg, pcnt_next;
  logic [BW-1:0]   bcnt_reg, bcnt_next;
  logic [BW-1:0]   bcnt_inc;
  logic            tick;

  assign tick     = pcnt_reg[PW-1];
  assign bcnt_inc = bcnt_reg + BW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pcnt_reg  <= '0;
      bcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      pcnt_reg  <= pcnt_next;
      bcnt_reg  <= bcnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pcnt_next  = pcnt_reg;
    bcnt_next  = bcnt_reg;
    case (state_reg)
      IDLE: begin
        if (start_i && !abort_i) begin
          state_next = RUN;
          pcnt_next  = PSTOP;
          bcnt_next  = BSTOP;
        end
      end
      RUN: begin
        if (abort_i) begin
          state_next = IDLE;
          pcnt_next  = '0;
          bcnt_next  = '0;
        end else if (tick) begin
          // The burst counter's incremented MSB marks the final tick of the burst.
          if (bcnt_inc[BW-1]) begin
            state_next = DONE;
            pcnt_next  = '0;
            bcnt_next  = '0;
          end else begin
            pcnt_next  = PRELOAD;
            bcnt_next  = bcnt_inc;
          end
        end else begin
          pcnt_next = pcnt_reg + PW'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        pcnt_next  = '0;
        bcnt_next  = '0;
      end
    endcase
  end

  // Counters are cleared on every exit from RUN, so the MSB alone serves as tick_o.
  assign tick_o = tick;
  assign busy_o = (state_reg == RUN);
  assign done_o = (state_reg == DONE);

endmodule

// File: tb/tb_tc_pulse_train.sv
module tb_tc_pulse_train;

    logic clk;
    logic rst_n;
    logic start5, abort5, busy5, tick5, done5;
    logic start4, abort4, busy4, tick4, done4;
    logic start2, abort2, busy2, tick2, done2;

    int cyc;
    int n_cmp;
    int n_bad;

    tc_pulse_train #(.PERIOD(5), .BURST(3)) u5 (
        .clk(clk), .rst_n(rst_n), .start_i(start5), .abort_i(abort5),
        .busy_o(busy5), .tick_o(tick5), .done_o(done5)
    );

    tc_pulse_train #(.PERIOD(4), .BURST(2)) u4 (
        .clk(clk), .rst_n(rst_n), .start_i(start4), .abort_i(abort4),
        .busy_o(busy4), .tick_o(tick4), .done_o(done4)
    );

    tc_pulse_train #(.PERIOD(2), .BURST(1)) u2 (
        .clk(clk), .rst_n(rst_n), .start_i(start2), .abort_i(abort2),
        .busy_o(busy2), .tick_o(tick2), .done_o(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic fail(input string tag, input logic obs, input logic exp);
        n_bad++;
        $display("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d observed=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic e;
        n_cmp  = 0;
        n_bad  = 0;
        cyc    = 0;
        rst_n  = 1'b0;
        start5 = 1'b0; abort5 = 1'b0;
        start4 = 1'b0; abort4 = 1'b0;
        start2 = 1'b0; abort2 = 1'b0;

        #2;
        n_cmp++; if (busy5 !== 1'b0) fail("rst_busy5", busy5, 1'b0);
        n_cmp++; if (tick5 !== 1'b0) fail("rst_tick5", tick5, 1'b0);
        n_cmp++; if (done5 !== 1'b0) fail("rst_done5", done5, 1'b0);
        n_cmp++; if (busy4 !== 1'b0) fail("rst_busy4", busy4, 1'b0);
        n_cmp++; if (busy2 !== 1'b0) fail("rst_busy2", busy2, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        step();
        n_cmp++; if (busy5 !== 1'b0) fail("idle_busy5", busy5, 1'b0);

        $display("burst: all instances started at edge 0, P2 start held high");
        start5 = 1'b1; start4 = 1'b1; start2 = 1'b1;
        cyc = -1;
        step();
        start4 = 1'b0;
        for (int c = 0; c < 20; c++) begin
            e = (c <= 15);
            n_cmp++; if (busy5 !== e) fail("a_busy5", busy5, e);
            e = (c == 5 || c == 10 || c == 15);
            n_cmp++; if (tick5 !== e) fail("a_tick5", tick5, e);
            e = (c == 16);
            n_cmp++; if (done5 !== e) fail("a_done5", done5, e);
            e = (c <= 8);
            n_cmp++; if (busy4 !== e) fail("a_busy4", busy4, e);
            e = (c == 4 || c == 8);
            n_cmp++; if (tick4 !== e) fail("a_tick4", tick4, e);
            e = (c == 9);
            n_cmp++; if (done4 !== e) fail("a_done4", done4, e);
            e = ((c % 5) <= 2);
            n_cmp++; if (busy2 !== e) fail("a_busy2", busy2, e);
            e = ((c % 5) == 2);
            n_cmp++; if (tick2 !== e) fail("a_tick2", tick2, e);
            e = ((c % 5) == 3);
            n_cmp++; if (done2 !== e) fail("a_done2", done2, e);
            start5 = (c == 3);
            start2 = (c < 19);
            step();
        end
        step();
        step();

        $display("abort: P5 abort in cycle 7, P4 start+abort in idle, P2 abort on last tick");
        start5 = 1'b1; start4 = 1'b1; abort4 = 1'b1; start2 = 1'b1;
        cyc = -1;
        step();
        start5 = 1'b0; start4 = 1'b0; start2 = 1'b0; abort4 = 1'b0;
        for (int c = 0; c < 20; c++) begin
            e = (c <= 7);
            n_cmp++; if (busy5 !== e) fail("b_busy5", busy5, e);
            e = (c == 5);
            n_cmp++; if (tick5 !== e) fail("b_tick5", tick5, e);
            n_cmp++; if (done5 !== 1'b0) fail("b_done5", done5, 1'b0);
            n_cmp++; if (busy4 !== 1'b0) fail("b_busy4", busy4, 1'b0);
            n_cmp++; if (tick4 !== 1'b0) fail("b_tick4", tick4, 1'b0);
            e = (c <= 2);
            n_cmp++; if (busy2 !== e) fail("b_busy2", busy2, e);
            e = (c == 2);
            n_cmp++; if (tick2 !== e) fail("b_tick2", tick2, e);
            n_cmp++; if (done2 !== 1'b0) fail("b_done2", done2, 1'b0);
            abort5 = (c == 7);
            abort4 = ((c % 4) == 0);
            abort2 = (c == 2);
            step();
        end
        abort5 = 1'b0; abort4 = 1'b0; abort2 = 1'b0;
        step();

        $display("reset: P5 burst interrupted by reset in cycle 12");
        start5 = 1'b1;
        cyc = -1;
        step();
        start5 = 1'b0;
        for (int c = 0; c < 12; c++) begin
            n_cmp++; if (busy5 !== 1'b1) fail("c_busy5", busy5, 1'b1);
            e = (c == 5 || c == 10);
            n_cmp++; if (tick5 !== e) fail("c_tick5", tick5, e);
            step();
        end
        n_cmp++; if (busy5 !== 1'b1) fail("c12_busy5", busy5, 1'b1);
        rst_n = 1'b0;
        #2;
        n_cmp++; if (busy5 !== 1'b0) fail("c12_rst_busy5", busy5, 1'b0);
        n_cmp++; if (tick5 !== 1'b0) fail("c12_rst_tick5", tick5, 1'b0);
        n_cmp++; if (done5 !== 1'b0) fail("c12_rst_done5", done5, 1'b0);
        #2;
        rst_n = 1'b1;
        for (int c = 13; c < 22; c++) begin
            step();
            n_cmp++; if (busy5 !== 1'b0) fail("c_post_busy5", busy5, 1'b0);
            n_cmp++; if (tick5 !== 1'b0) fail("c_post_tick5", tick5, 1'b0);
            n_cmp++; if (done5 !== 1'b0) fail("c_post_done5", done5, 1'b0);
        end

        $display("restart: fresh P5 burst after reset");
        start5 = 1'b1;
        cyc = -1;
        step();
        start5 = 1'b0;
        for (int c = 0; c < 18; c++) begin
            e = (c <= 15);
            n_cmp++; if (busy5 !== e) fail("d_busy5", busy5, e);
            e = (c == 5 || c == 10 || c == 15);
            n_cmp++; if (tick5 !== e) fail("d_tick5", tick5, e);
            e = (c == 16);
            n_cmp++; if (done5 !== e) fail("d_done5", done5, e);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
